// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// shift direction type and a small mode-decode helper.
package universal_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_SHIFT_L = 2'b01;
    localparam logic [1:0] MODE_SHIFT_R = 2'b10;
    localparam logic [1:0] MODE_LOAD    = 2'b11;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == MODE_SHIFT_L) || (mode == MODE_SHIFT_R);
    endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle of the universal shift register. The master side
// drives mode and data; the slave side (the register) returns its state.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
) ();
    import universal_shift_reg_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic             enable;
    logic [1:0]       mode;
    logic             rotate;
    logic             serial_in;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic [CNT_W-1:0] count;
    logic             word_done;

    modport master (
        output enable, mode, rotate, serial_in, load_data,
        input  data_out, serial_out, count, word_done
    );

    modport slave (
        input  enable, mode, rotate, serial_in, load_data,
        output data_out, serial_out, count, word_done
    );

endinterface

// File: rtl/universal_shift_reg_word_counter.sv
// Counts shifts within a word of MAX bits and emits a registered one-cycle
// pulse when the MAX-th shift completes. Reusable by deserialisers.
module word_counter #(
    parameter  int MAX   = 8,
    localparam int CNT_W = $clog2(MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             done_pulse
);
    import universal_shift_reg_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

    // Advance/wrap the in-word count; clear discards a partial word silently.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count      <= '0;
            done_pulse <= 1'b0;
        end else if (inc) begin
            if (count == LAST) begin
                count      <= '0;
                done_pulse <= 1'b1;
            end else begin
                count      <= count + 1'b1;
                done_pulse <= 1'b0;
            end
        end else begin
            done_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: left/right shift, rotate and parallel load,
// with a word counter flagging every completed word of WIDTH shifts.
module universal_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    universal_shift_reg_if.slave bus
);
    import universal_shift_reg_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    dir_t             last_dir;
    logic             shift_l;
    logic             shift_r;
    logic             do_load;
    logic             in_l;
    logic             in_r;
    logic [CNT_W-1:0] count;
    logic             word_done;

    assign shift_l = bus.enable && (bus.mode == MODE_SHIFT_L);
    assign shift_r = bus.enable && (bus.mode == MODE_SHIFT_R);
    assign do_load = bus.enable && (bus.mode == MODE_LOAD);

    // Bit entering at the vacated end: the leaving bit when rotating.
    assign in_l = bus.rotate ? shreg[WIDTH-1] : bus.serial_in;
    assign in_r = bus.rotate ? shreg[0]       : bus.serial_in;

    // Shift/load datapath and the direction of the most recent shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= RESET_VALUE;
            last_dir <= DIR_L;
        end else if (shift_l) begin
            shreg    <= {shreg[WIDTH-2:0], in_l};
            last_dir <= DIR_L;
        end else if (shift_r) begin
            shreg    <= {in_r, shreg[WIDTH-1:1]};
            last_dir <= DIR_R;
        end else if (do_load) begin
            shreg    <= bus.load_data;
        end
    end

    word_counter #(
        .MAX (WIDTH)
    ) u_word_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (shift_l || shift_r),
        .clr        (do_load),
        .count      (count),
        .done_pulse (word_done)
    );

    assign bus.data_out   = shreg;
    assign bus.serial_out = (last_dir == DIR_L) ? shreg[WIDTH-1] : shreg[0];
    assign bus.count      = count;
    assign bus.word_done  = word_done;

`ifdef FORMAL
    logic past_valid;

    // Properties are only meaningful once the first reset has been seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            past_valid <= 1'b1;
        end
    end

    // Invariants on count range, pulse origin and serial entry bit.
    always @(posedge clk) begin
        if (past_valid && !reset && !$past(reset)) begin
            assert (count <= CNT_W'(WIDTH - 1));
            if (word_done) begin
                assert (($past(shift_l) || $past(shift_r)) && ($past(count) == CNT_W'(WIDTH - 1)));
            end
            if ($past(shift_l) && !$past(bus.rotate)) begin
                assert (shreg[0] == $past(bus.serial_in));
            end
            if ($past(shift_r) && !$past(bus.rotate)) begin
                assert (shreg[WIDTH-1] == $past(bus.serial_in));
            end
        end
    end
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VALUE=0).
module tb_universal_shift_reg;
    import universal_shift_reg_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    universal_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    universal_shift_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] m, input logic rot,
                         input logic si, input logic [7:0] ld);
        bus.enable    = en;
        bus.mode      = m;
        bus.rotate    = rot;
        bus.serial_in = si;
        bus.load_data = ld;
    endtask

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] si_pat;
    logic [7:0] so_pat;
    logic [7:0] rot_exp [8];
    logic [7:0] flip_exp [8];
    logic       flip_so [8];

    initial begin
        si_pat   = 8'b1011_0010;
        so_pat   = 8'hA5;
        rot_exp  = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        flip_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0};
        flip_so  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // 1: reset dominates a LOAD of FF
        reset = 1'b1;
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
        step();
        step();
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_count", bus.count, 0);
        chk("rst_done", bus.word_done, 0);
        chk("rst_sout", bus.serial_out, 0);
        reset = 1'b0;

        // 2: LOAD A5 then 8 left shifts
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
        step();
        chk("t2_load", bus.data_out, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_sout%0d", i), bus.serial_out, so_pat[7-i]);
            drive(1'b1, MODE_SHIFT_L, 1'b0, si_pat[7-i], 8'h00);
            step();
            chk($sformatf("t2_cnt%0d", i), bus.count, (i + 1) % 8);
            chk($sformatf("t2_done%0d", i), bus.word_done, (i == 7));
        end
        chk("t2_data", bus.data_out, 8'hB2);
        drive(1'b1, MODE_HOLD, 1'b0, 1'b1, 8'h00);
        step();
        chk("t2_hold_done", bus.word_done, 0);
        chk("t2_hold_data", bus.data_out, 8'hB2);
        chk("t2_hold_cnt", bus.count, 0);

        // 3: rotate right from 81
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, MODE_SHIFT_R, 1'b1, 1'b0, 8'h00);
            step();
            chk($sformatf("t3_data%0d", i), bus.data_out, rot_exp[i]);
            chk($sformatf("t3_sout%0d", i), bus.serial_out, rot_exp[i][0]);
            chk($sformatf("t3_done%0d", i), bus.word_done, (i == 7));
        end
        drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
        step();
        chk("t3_done_after", bus.word_done, 0);

        // 4: 3 shifts, 5-cycle enable gap, 5 shifts
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, MODE_SHIFT_L, 1'b0, 1'b1, 8'h00);
            step();
        end
        chk("t4_cnt3", bus.count, 3);
        chk("t4_data3", bus.data_out, 8'h07);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, MODE_SHIFT_L, 1'b0, 1'b1, 8'hFF);
            step();
            chk($sformatf("t4_gap_cnt%0d", i), bus.count, 3);
            chk($sformatf("t4_gap_data%0d", i), bus.data_out, 8'h07);
            chk($sformatf("t4_gap_done%0d", i), bus.word_done, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, MODE_SHIFT_L, 1'b0, 1'b1, 8'h00);
            step();
            chk($sformatf("t4_done%0d", i), bus.word_done, (i == 4));
            chk($sformatf("t4_cnt%0d", i), bus.count, (i + 4) % 8);
        end
        chk("t4_data", bus.data_out, 8'hFF);

        // 5a: reset after 5 shifts
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, MODE_SHIFT_L, 1'b0, 1'b0, 8'h00);
            step();
        end
        chk("t5_cnt5", bus.count, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_cnt", bus.count, 0);
        chk("t5_rst_done", bus.word_done, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, MODE_SHIFT_L, 1'b0, 1'b0, 8'h00);
            step();
            chk($sformatf("t5_rst_post_done%0d", i), bus.word_done, 0);
        end
        chk("t5_rst_post_cnt", bus.count, 3);

        // 5b: LOAD 3C after 5 shifts
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, MODE_SHIFT_L, 1'b0, 1'b0, 8'h00);
            step();
        end
        chk("t5_ld_cnt5", bus.count, 5);
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
        step();
        chk("t5_ld_cnt", bus.count, 0);
        chk("t5_ld_data", bus.data_out, 8'h3C);
        chk("t5_ld_done", bus.word_done, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, MODE_SHIFT_L, 1'b0, 1'b0, 8'h00);
            step();
            chk($sformatf("t5_ld_post_done%0d", i), bus.word_done, 0);
        end
        chk("t5_ld_post_cnt", bus.count, 3);
        chk("t5_ld_post_data", bus.data_out, 8'hE0);

        // 6: 4 left then 4 right shifts, serial_in=1
        drive(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i < 4) ? MODE_SHIFT_L : MODE_SHIFT_R, 1'b0, 1'b1, 8'h00);
            step();
            chk($sformatf("t6_data%0d", i), bus.data_out, flip_exp[i]);
            chk($sformatf("t6_sout%0d", i), bus.serial_out, flip_so[i]);
            chk($sformatf("t6_cnt%0d", i), bus.count, (i + 1) % 8);
            chk($sformatf("t6_done%0d", i), bus.word_done, (i == 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
